pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32 pipeline. Drives the hold and flush controls of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. Resolves four conditions:
//  - load-use hazards
//  - taken branches/jumps
//  - instruction-memory busy-wait
//  - data-memory busy-wait

---
 rtl/pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage RV32 pipeline. Generates the hold,
// flush and bubble controls for the pipeline registers and the PC write
// enable from load-use, taken-branch, I-cache and D-cache wait conditions.
// Control outputs are combinational from the registered state plus inputs.
//
// Build option: define HAZARD_PERF_CNT_EN to implement the STALL_COUNT and
// FLUSH_COUNT performance counters; otherwise both ports read 32'd0.

module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_AW       = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IMEM_BUSY_WAIT,
    input  logic              DMEM_BUSY_WAIT,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] EX_RD,
    input  logic              EX_MEM_READ,
    input  logic              BRANCH_TAKEN,
    output logic              PC_WRITE_EN,
    output logic              PC_SEL_TARGET,
    output logic              IF_ID_HOLD,
    output logic              IF_ID_FLUSH,
    output logic              ID_EX_BUBBLE,
    output logic              EX_MEM_HOLD,
    output logic              MEM_WB_HOLD,
    output logic [31:0]       STALL_COUNT,
    output logic [31:0]       FLUSH_COUNT
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DWAIT = 2'd2
    } state_t;

    // FLUSH_CYCLES is limited to 1..7, so three bits hold any reload value.
    localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      saved_r;       // state to resume once the D-cache wait ends
    state_t      saved_nxt_s;
    state_t      eff_s;         // state whose rules apply this cycle
    logic [2:0]  fcnt_r;
    logic [2:0]  fcnt_nxt_s;
    logic        lu_s;

    logic        pc_write_en_s;
    logic        pc_sel_target_s;
    logic        if_id_hold_s;
    logic        if_id_flush_s;
    logic        id_ex_bubble_s;
    logic        ex_mem_hold_s;
    logic        mem_wb_hold_s;

    // Load-use detect: a load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_s = EX_MEM_READ
            && (EX_RD != {REG_AW{1'b0}})
            && ((EX_RD == ID_RS1) || (EX_RD == ID_RS2));
    end

    // Leaving DWAIT resumes the saved state, evaluated in the same cycle.
    always_comb begin
        if (state_r == ST_DWAIT) begin
            eff_s = saved_r;
        end else begin
            eff_s = state_r;
        end
    end

    // Next-state, flush counter and control outputs in priority order.
    always_comb begin
        pc_write_en_s   = 1'b0;
        pc_sel_target_s = 1'b0;
        if_id_hold_s    = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_bubble_s  = 1'b0;
        ex_mem_hold_s   = 1'b0;
        mem_wb_hold_s   = 1'b0;
        state_nxt_s     = state_r;
        saved_nxt_s     = saved_r;
        fcnt_nxt_s      = fcnt_r;

        if (RESET) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            state_nxt_s    = ST_RUN;
            saved_nxt_s    = ST_RUN;
            fcnt_nxt_s     = 3'd0;
        end else if (DMEM_BUSY_WAIT) begin
            // Freeze everything; EX re-presents any branch once memory is ready.
            if_id_hold_s  = 1'b1;
            ex_mem_hold_s = 1'b1;
            mem_wb_hold_s = 1'b1;
            state_nxt_s   = ST_DWAIT;
            saved_nxt_s   = eff_s;
        end else if (BRANCH_TAKEN) begin
            // Squash the younger instructions; any load-use in ID dies with them.
            pc_sel_target_s = 1'b1;
            pc_write_en_s   = 1'b1;
            if_id_flush_s   = 1'b1;
            id_ex_bubble_s  = 1'b1;
            saved_nxt_s     = ST_RUN;
            if (FLUSH_CYCLES > 1) begin
                state_nxt_s = ST_FLUSH;
                fcnt_nxt_s  = FCNT_LOAD;
            end else begin
                state_nxt_s = ST_RUN;
                fcnt_nxt_s  = 3'd0;
            end
        end else begin
            case (eff_s)
                ST_FLUSH: begin
                    // ID holds a NOP here, so load-use is not checked.
                    if_id_flush_s = 1'b1;
                    pc_write_en_s = 1'b1;
                    if (fcnt_r <= 3'd1) begin
                        state_nxt_s = ST_RUN;
                        fcnt_nxt_s  = 3'd0;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        fcnt_nxt_s  = fcnt_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    if (lu_s) begin
                        // One bubble suffices: next cycle the bubble sits in EX.
                        if_id_hold_s   = 1'b1;
                        id_ex_bubble_s = 1'b1;
                    end else if (IMEM_BUSY_WAIT) begin
                        // Fetch stalls; later stages keep draining.
                        if_id_flush_s = 1'b1;
                    end else begin
                        pc_write_en_s = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, saved state and flush counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_RUN;
            saved_r <= ST_RUN;
            fcnt_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            saved_r <= saved_nxt_s;
            fcnt_r  <= fcnt_nxt_s;
        end
    end

    assign PC_WRITE_EN   = pc_write_en_s;
    assign PC_SEL_TARGET = pc_sel_target_s;
    assign IF_ID_HOLD    = if_id_hold_s;
    assign IF_ID_FLUSH   = if_id_flush_s;
    assign ID_EX_BUBBLE  = id_ex_bubble_s;
    assign EX_MEM_HOLD   = ex_mem_hold_s;
    assign MEM_WB_HOLD   = mem_wb_hold_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        flush_evt_s;

    // A branch is acted on only when the D-cache is not holding the pipe.
    always_comb begin
        flush_evt_s = BRANCH_TAKEN && !DMEM_BUSY_WAIT;
    end

    // Performance counters; both wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (!pc_write_en_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign STALL_COUNT = stall_cnt_r;
    assign FLUSH_COUNT = flush_cnt_r;
`else
    assign STALL_COUNT = 32'd0;
    assign FLUSH_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2). Inputs change 1ns
// after each rising edge; control outputs are checked on the falling edge and
// counters 1ns after the rising edge that updates them.

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: {PC_WE, PC_SEL, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_HOLD, MEM_WB_HOLD}
    localparam logic [6:0] C_RESET = 7'b0001100;
    localparam logic [6:0] C_RUN   = 7'b1000000;
    localparam logic [6:0] C_LU    = 7'b0010100;
    localparam logic [6:0] C_BR    = 7'b1101100;
    localparam logic [6:0] C_FL    = 7'b1001000;
    localparam logic [6:0] C_DW    = 7'b0010011;
    localparam logic [6:0] C_IM    = 7'b0001000;

    logic        clk;
    logic        reset;
    logic        imem_busy_wait;
    logic        dmem_busy_wait;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        branch_taken;
    logic        pc_write_en;
    logic        pc_sel_target;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_hold;
    logic        mem_wb_hold;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
    logic [6:0]  ctrl;

    int checks;
    int failures;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .REG_AW(5)) dut (
        .CLK           (clk),
        .RESET         (reset),
        .IMEM_BUSY_WAIT(imem_busy_wait),
        .DMEM_BUSY_WAIT(dmem_busy_wait),
        .ID_RS1        (id_rs1),
        .ID_RS2        (id_rs2),
        .EX_RD         (ex_rd),
        .EX_MEM_READ   (ex_mem_read),
        .BRANCH_TAKEN  (branch_taken),
        .PC_WRITE_EN   (pc_write_en),
        .PC_SEL_TARGET (pc_sel_target),
        .IF_ID_HOLD    (if_id_hold),
        .IF_ID_FLUSH   (if_id_flush),
        .ID_EX_BUBBLE  (id_ex_bubble),
        .EX_MEM_HOLD   (ex_mem_hold),
        .MEM_WB_HOLD   (mem_wb_hold),
        .STALL_COUNT   (stall_count),
        .FLUSH_COUNT   (flush_count)
    );

    assign ctrl = {pc_write_en, pc_sel_target, if_id_hold, if_id_flush,
                   id_ex_bubble, ex_mem_hold, mem_wb_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: check controls on the falling edge, then step past the rising edge.
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check_val(tag, {25'd0, ctrl}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int s, input int f);
        check_val({tag, "_stall"}, stall_count, PERF ? 32'(s) : 32'd0);
        check_val({tag, "_flush"}, flush_count, PERF ? 32'(f) : 32'd0);
    endtask

    task automatic idle_inputs();
        imem_busy_wait = 1'b0;
        dmem_busy_wait = 1'b0;
        id_rs1         = 5'd0;
        id_rs2         = 5'd0;
        ex_rd          = 5'd0;
        ex_mem_read    = 1'b0;
        branch_taken   = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset for two cycles, then the first RUN cycle
        cyc("rst0", C_RESET);
        cyc("rst1", C_RESET);
        check_cnt("rst", 0, 0);
        reset = 1'b0;
        cyc("run0", C_RUN);

        // Load-use via RS2, then the bubble clears it
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        cyc("lu_rs2", C_LU);
        idle_inputs();
        cyc("lu_after", C_RUN);
        // x0 never creates a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_x0", C_RUN);
        // Load-use via RS1
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
        cyc("lu_rs1", C_LU);
        // Non-matching registers
        id_rs1 = 5'd6; id_rs2 = 5'd8;
        cyc("lu_miss", C_RUN);
        // Matching register but not a load
        ex_mem_read = 1'b0; id_rs1 = 5'd7;
        cyc("lu_noload", C_RUN);
        idle_inputs();
        check_cnt("lu", 2, 0);

        // Branch: one target cycle, two flush cycles
        branch_taken = 1'b1;
        cyc("br", C_BR);
        branch_taken = 1'b0;
        cyc("br_fl", C_FL);
        cyc("br_run", C_RUN);
        check_cnt("br", 2, 1);

        // D-cache wait arriving in FLUSH with one flush cycle left
        branch_taken = 1'b1;
        cyc("br2", C_BR);
        branch_taken = 1'b0;
        dmem_busy_wait = 1'b1;
        for (int i = 0; i < 4; i++) cyc($sformatf("dw%0d", i), C_DW);
        dmem_busy_wait = 1'b0;
        cyc("dw_fl", C_FL);
        cyc("dw_run", C_RUN);
        check_cnt("dw", 6, 2);

        // Branch under D-cache wait is ignored, then acted on when re-presented
        dmem_busy_wait = 1'b1; branch_taken = 1'b1;
        cyc("dwbr_hold", C_DW);
        dmem_busy_wait = 1'b0;
        cyc("dwbr_br", C_BR);
        branch_taken = 1'b0;
        cyc("dwbr_fl", C_FL);
        cyc("dwbr_run", C_RUN);
        check_cnt("dwbr", 7, 3);

        // Branch and load-use together: branch response only
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; branch_taken = 1'b1;
        cyc("brlu", C_BR);
        idle_inputs();
        cyc("brlu_fl", C_FL);
        cyc("brlu_run", C_RUN);

        // I-cache wait for three cycles
        imem_busy_wait = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("im%0d", i), C_IM);
        imem_busy_wait = 1'b0;
        cyc("im_run", C_RUN);
        check_cnt("im", 10, 4);

        // Load-use pending when a D-cache wait ends is seen in that same cycle
        dmem_busy_wait = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        cyc("dwlu_hold", C_DW);
        dmem_busy_wait = 1'b0;
        cyc("dwlu_lu", C_LU);
        idle_inputs();
        cyc("dwlu_run", C_RUN);

        // Reset in the middle of a D-cache wait entered from FLUSH
        branch_taken = 1'b1;
        cyc("rdw_br", C_BR);
        branch_taken = 1'b0; dmem_busy_wait = 1'b1;
        cyc("rdw_hold", C_DW);
        reset = 1'b1;
        cyc("rdw_rst", C_RESET);
        check_cnt("rdw", 0, 0);
        reset = 1'b0; dmem_busy_wait = 1'b0;
        cyc("rdw_run", C_RUN);
        cyc("rdw_run2", C_RUN);
        check_cnt("rdw_after", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
